fetch: RTL

Instruction fetch stage of the TERC core, directly upstream of the instruction decoder. Maintains the program counter, issues word reads to instruction memory over a req/ack handshake, buffers returned words, and presents one instruction per cycle on `inst` for the decoder to latch. Inserts NOPs (16'h0000) when no instruction is available. Supports stall from downstream and redirect (jump) with discard of in-flight fetches.

---
 rtl/fetch.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fetch.sv
// TERC instruction fetch: program counter, imem req/ack handshake, instruction buffer, NOP insertion.
// Optional FETCH_PREFETCH_EN selects a 2-entry buffer (1 instr/cycle); otherwise a single entry.
module fetch #(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] NOP_WORD = '0
) (
    input  logic             clk,
    input  logic             res,
    input  logic             stall,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_addr,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_data,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc,
    output logic             inst_valid
);

`ifdef FETCH_PREFETCH_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [WIDTH-1:0] addr;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DROP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             req_d;
    logic [WIDTH-1:0] addr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [OCC_W-1:0] wr_idx;
    entry_t           buf_q [DEPTH];
    entry_t           buf_d [DEPTH];
    logic [WIDTH-1:0] inst_d, inst_pc_d;
    logic             inst_valid_d;
    logic             ack_c, push_c, pop_c, free_c;

    // Occupancy bookkeeping; a jump flushes the buffer and swallows any same-cycle ack.
    always_comb begin : occupancy
        ack_c  = imem_req && imem_ack;
        push_c = !jump && (state_q == BUSY) && ack_c;
        pop_c  = !jump && !stall && (occ_q != '0);
        if (jump) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OCC_W'(push_c) - OCC_W'(pop_c);
        end
        free_c = occ_d < OCC_W'(DEPTH);
    end

    // Head-at-index-0 shift buffer; the new word lands behind whatever survives the pop.
    always_comb begin : buffer_next
        buf_d  = buf_q;
        wr_idx = occ_q - OCC_W'(pop_c);
        if (pop_c) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                buf_d[i] = buf_q[i+1];
            end
        end
        if (push_c) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (OCC_W'(i) == wr_idx) begin
                    buf_d[i] = '{data: imem_data, addr: imem_addr};
                end
            end
        end
    end

    // Request FSM; an outstanding unacked request must drain through DROP before redirecting.
    always_comb begin : fsm_next
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = imem_req;
        addr_d  = imem_addr;
        if (jump) begin
            pc_d = jump_addr;
            if ((state_q != IDLE) && !ack_c) begin
                state_d = DROP;
            end else begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (free_c) begin
                        state_d = BUSY;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
                BUSY: begin
                    if (ack_c) begin
                        pc_d = pc_q + WIDTH'(1);
                        if (free_c) begin
                            addr_d = pc_q + WIDTH'(1);
                        end else begin
                            state_d = IDLE;
                            req_d   = 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (ack_c) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    // Issue toward the decoder; inst_pc keeps the last real address while NOPs go out.
    always_comb begin : issue_next
        inst_d       = inst;
        inst_pc_d    = inst_pc;
        inst_valid_d = inst_valid;
        if (jump) begin
            inst_d       = NOP_WORD;
            inst_valid_d = 1'b0;
        end else if (!stall) begin
            if (occ_q != '0) begin
                inst_d       = buf_q[0].data;
                inst_pc_d    = buf_q[0].addr;
                inst_valid_d = 1'b1;
            end else begin
                inst_d       = NOP_WORD;
                inst_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin : regs
        if (!res) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            occ_q      <= '0;
            inst       <= NOP_WORD;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            imem_req   <= req_d;
            imem_addr  <= addr_d;
            occ_q      <= occ_d;
            inst       <= inst_d;
            inst_pc    <= inst_pc_d;
            inst_valid <= inst_valid_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

endmodule
